// File: rtl/arbitre_additionneur_16bit_pkg.sv
// Shared definitions for the arbitrated 16-bit adder: state encodings,
// operand width, saturation value and the saturation helper.
package arbitre_additionneur_16bit_pkg;

    localparam int OP_W = 16;

    localparam logic [1:0] ETAT_IDLE = 2'd0;
    localparam logic [1:0] ETAT_CALC = 2'd1;
    localparam logic [1:0] ETAT_RESP = 2'd2;

    localparam logic [OP_W-1:0] SAT_VALUE = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = ETAT_IDLE,
        ST_CALC = ETAT_CALC,
        ST_RESP = ETAT_RESP
    } etat_t;

    // Clamp a sum to the saturation value when the adder overflowed.
    function automatic logic [OP_W-1:0] saturer(input logic [OP_W-1:0] s_in,
                                                 input logic            rout_in);
        if (rout_in) begin
            return SAT_VALUE;
        end else begin
            return s_in;
        end
    endfunction

endpackage

// File: rtl/additionneur_16bit.sv
// 16-bit unsigned ripple-carry adder: {rout, s} = a + b + rin, built from
// explicit full-adder cells.
module additionneur_16bit
    import arbitre_additionneur_16bit_pkg::*;
(
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    input  logic            rin,
    output logic [OP_W-1:0] s,
    output logic            rout
);

    logic [OP_W:0] carry_s;

    assign carry_s[0] = rin;

    for (genvar gi = 0; gi < OP_W; gi++) begin : g_fa
        // One full-adder cell per bit; carry ripples upwards.
        assign s[gi]           = a[gi] ^ b[gi] ^ carry_s[gi];
        assign carry_s[gi + 1] = (a[gi] & b[gi]) | (carry_s[gi] & (a[gi] ^ b[gi]));
    end

    assign rout = carry_s[OP_W];

endmodule

// File: rtl/arbitre_rr.sv
// Combinational round-robin picker: selects the first set req_valid bit at
// or after rr_ptr, wrapping modulo N_REQ.
module arbitre_rr #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx,
    output logic             any_valid
);

    logic [ID_W:0]   sum_s;
    logic [ID_W-1:0] pos_s;

    // Scan requesters starting at rr_ptr and keep the first one found.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        sum_s     = '0;
        pos_s     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum_s = {1'b0, rr_ptr} + (ID_W + 1)'(i);
            if (sum_s >= (ID_W + 1)'(N_REQ)) begin
                sum_s = sum_s - (ID_W + 1)'(N_REQ);
            end else begin
                sum_s = sum_s;
            end
            pos_s = sum_s[ID_W-1:0];
            if (!any_valid && req_valid[pos_s]) begin
                grant_idx = pos_s;
                any_valid = 1'b1;
            end else begin
                any_valid = any_valid;
            end
        end
        grant[grant_idx] = any_valid;
    end

endmodule

// File: rtl/arbitre_additionneur_16bit.sv
// Round-robin arbiter sharing one additionneur_16bit between N_REQ
// requesters. Operands are registered on grant, added during CALC, and the
// result is held in RESP until the consumer accepts it.
// Optional build macro: ARBITRE_SATURATION_EN clamps rsp_s to 16'hFFFF on
// carry-out (rsp_rout still reports the carry).
module arbitre_additionneur_16bit
    import arbitre_additionneur_16bit_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [OP_W*N_REQ-1:0] req_a,
    input  logic [OP_W*N_REQ-1:0] req_b,
    input  logic [N_REQ-1:0]      req_rin,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [OP_W-1:0]       rsp_s,
    output logic                  rsp_rout,
    output logic                  busy,
    output logic [15:0]           nb_ops
);

    etat_t           state_r;
    etat_t           state_nx_s;

    logic [N_REQ-1:0] grant_s;
    logic [ID_W-1:0]  grant_idx_s;
    logic             any_valid_s;
    logic [ID_W-1:0]  rr_ptr_r;
    logic [ID_W-1:0]  rr_ptr_nx_s;

    logic [OP_W-1:0]  a_slot_s [N_REQ];
    logic [OP_W-1:0]  b_slot_s [N_REQ];

    logic [OP_W-1:0]  op_a_r;
    logic [OP_W-1:0]  op_b_r;
    logic             op_rin_r;
    logic [ID_W-1:0]  id_r;

    logic [OP_W-1:0]  add_s_s;
    logic             add_rout_s;
    logic [OP_W-1:0]  sum_sel_s;

    logic             req_fire_s;
    logic             calc_done_s;
    logic             rsp_fire_s;

    logic             rsp_valid_r;
    logic [ID_W-1:0]  rsp_id_r;
    logic [OP_W-1:0]  rsp_s_r;
    logic             rsp_rout_r;
    logic             busy_r;
    logic [15:0]      nb_ops_r;

    // Unpack the per-requester operand buses into indexable slots.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slot
        assign a_slot_s[gi] = req_a[OP_W*gi +: OP_W];
        assign b_slot_s[gi] = req_b[OP_W*gi +: OP_W];
    end

    arbitre_rr #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .any_valid (any_valid_s)
    );

    additionneur_16bit u_add (
        .a    (op_a_r),
        .b    (op_b_r),
        .rin  (op_rin_r),
        .s    (add_s_s),
        .rout (add_rout_s)
    );

    // Select raw or saturated sum for the response register.
    always_comb begin
        sum_sel_s = add_s_s;
`ifdef ARBITRE_SATURATION_EN
        sum_sel_s = saturer(add_s_s, add_rout_s);
`else
        sum_sel_s = add_s_s;
`endif
    end

    // Grant is visible only in IDLE and never while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (rst_n && (state_r == ST_IDLE)) begin
            req_ready = grant_s;
        end else begin
            req_ready = '0;
        end
    end

    // Pointer advances to the requester after the one just granted.
    always_comb begin
        rr_ptr_nx_s = '0;
        if (grant_idx_s == ID_W'(N_REQ - 1)) begin
            rr_ptr_nx_s = '0;
        end else begin
            rr_ptr_nx_s = grant_idx_s + 1'b1;
        end
    end

    // Next-state logic and the one-cycle strobes that drive the registers.
    always_comb begin
        state_nx_s  = state_r;
        req_fire_s  = 1'b0;
        calc_done_s = 1'b0;
        rsp_fire_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (any_valid_s) begin
                    state_nx_s = ST_CALC;
                    req_fire_s = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                state_nx_s  = ST_RESP;
                calc_done_s = 1'b1;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nx_s = ST_IDLE;
                    rsp_fire_s = 1'b1;
                end else begin
                    state_nx_s = ST_RESP;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Capture the granted requester's operands and advance the pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_r   <= 16'h0000;
            op_b_r   <= 16'h0000;
            op_rin_r <= 1'b0;
            id_r     <= '0;
            rr_ptr_r <= '0;
        end else if (req_fire_s) begin
            op_a_r   <= a_slot_s[grant_idx_s];
            op_b_r   <= b_slot_s[grant_idx_s];
            op_rin_r <= req_rin[grant_idx_s];
            id_r     <= grant_idx_s;
            rr_ptr_r <= rr_ptr_nx_s;
        end
    end

    // Response registers: loaded at the end of CALC, frozen until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= '0;
            rsp_s_r     <= 16'h0000;
            rsp_rout_r  <= 1'b0;
        end else if (calc_done_s) begin
            rsp_valid_r <= 1'b1;
            rsp_id_r    <= id_r;
            rsp_s_r     <= sum_sel_s;
            rsp_rout_r  <= add_rout_s;
        end else if (rsp_fire_s) begin
            rsp_valid_r <= 1'b0;
        end
    end

    // Busy flag tracks the state the FSM is about to enter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_nx_s != ST_IDLE);
        end
    end

    // Completed-response counter, wrapping naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nb_ops_r <= 16'h0000;
        end else if (rsp_fire_s) begin
            nb_ops_r <= nb_ops_r + 16'h0001;
        end else begin
            nb_ops_r <= nb_ops_r;
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_s     = rsp_s_r;
    assign rsp_rout  = rsp_rout_r;
    assign busy      = busy_r;
    assign nb_ops    = nb_ops_r;

endmodule
